nfc_command_read_status: RTL and testbench

Command-generator stage that issues a NAND READ STATUS (0x70) on one target way and returns the status byte. It drives the atomic command generator (ACG) interface through the shared command mux. When inactive it presents the idle ACG pattern, so it can be OR-muxed or selected alongside the idle generator. Upstream is the way scheduler, which issues iStart and consumes oStatus and oLastStep.

---
 rtl/nfc_command_read_status.sv | 168 ++++++++++++++++
 tb/tb_nfc_command_read_status.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_command_read_status.sv
// NAND READ STATUS (0x70) command generator for one target way.
// Presents the idle ACG pattern whenever no operation is in flight.
module nfc_command_read_status #(
  parameter int NumberOfWays = 4,
  parameter int WhrCycles    = 12
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic [NumberOfWays-1:0] iTargetWay,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic [7:0]              oStatus,
  output logic [7:0]              oACG_Command,
  output logic [2:0]              oACG_CommandOption,
  output logic [NumberOfWays-1:0] oACG_TargetWay,
  output logic [15:0]             oACG_NumOfData,
  output logic                    oACG_CASelect,
  output logic [39:0]             oACG_CAData,
  output logic [15:0]             oACG_WriteData,
  output logic                    oACG_WriteLast,
  output logic                    oACG_WriteValid,
  output logic                    oACG_ReadReady,
  input  logic                    iACG_Ready,
  input  logic                    iACG_LastStep,
  input  logic [15:0]             iACG_ReadData,
  input  logic                    iACG_ReadValid,
  input  logic                    iACG_ReadLast
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA_ISSUE,
    S_CA_WAIT,
    S_WHR,
    S_RD_ISSUE,
    S_RD_DATA,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam int CW = (WhrCycles > 1) ? $clog2(WhrCycles) : 1;
  localparam logic [CW-1:0] WHR_LOAD = CW'(WhrCycles - 1);

  state_t                  state_q, state_d;
  logic [NumberOfWays-1:0] way_q, way_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7:0]              status_q, status_d;
  logic                    first_q, first_d;

  // Only the low byte carries the status
  logic unused_rd_hi;
  assign unused_rd_hi = ^iACG_ReadData[15:8];

  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      state_q  <= S_IDLE;
      way_q    <= '0;
      cnt_q    <= '0;
      status_q <= 8'h00;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    way_d    = way_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    first_d  = first_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          status_d = 8'h00;
          if (|iTargetWay) begin
            way_d   = iTargetWay;
            state_d = S_CA_ISSUE;
          end else begin
            way_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_CA_ISSUE: begin
        if (iACG_Ready) state_d = S_CA_WAIT;
      end
      S_CA_WAIT: begin
        if (iACG_LastStep) begin
          cnt_d   = WHR_LOAD;
          state_d = S_WHR;
        end
      end
      S_WHR: begin
        if (cnt_q == '0) state_d = S_RD_ISSUE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RD_ISSUE: begin
        if (iACG_Ready) begin
          first_d = 1'b1;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (iACG_ReadValid) begin
          if (first_q) begin
            status_d = iACG_ReadData[7:0];
            first_d  = 1'b0;
          end
          if (iACG_ReadLast)
            state_d = iACG_LastStep ? S_DONE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (iACG_LastStep) state_d = S_DONE;
      end
      S_DONE: begin
        way_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oReady             = (state_q == S_IDLE);
    oLastStep          = (state_q == S_DONE);
    oStatus            = status_q;
    oACG_Command       = 8'h00;
    oACG_CommandOption = 3'b000;
    oACG_TargetWay     = '0;
    oACG_NumOfData     = 16'd0;
    oACG_CASelect      = 1'b1;
    oACG_CAData        = 40'h0;
    oACG_WriteData     = 16'h0000;
    oACG_WriteLast     = 1'b0;
    oACG_WriteValid    = 1'b0;
    oACG_ReadReady     = 1'b0;
    unique case (state_q)
      S_CA_ISSUE: begin
        oACG_Command   = 8'h03;
        oACG_CASelect  = 1'b0;
        oACG_CAData    = {32'h0, 8'h70};
        oACG_TargetWay = way_q;
      end
      S_RD_ISSUE: begin
        oACG_Command   = 8'h05;
        oACG_TargetWay = way_q;
      end
      S_RD_DATA: begin
        oACG_ReadReady = 1'b1;
        oACG_TargetWay = way_q;
      end
      S_CA_WAIT, S_WHR, S_RD_WAIT: begin
        oACG_TargetWay = way_q;
      end
      default: begin
        oACG_TargetWay = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_nfc_command_read_status.sv
// Directed bench for nfc_command_read_status.
// Each task drives one scenario and checks the outputs inline.
module tb_nfc_command_read_status;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iStart;
  logic [3:0]  iTargetWay;
  logic        oReady;
  logic        oLastStep;
  logic [7:0]  oStatus;
  logic [7:0]  oACG_Command;
  logic [2:0]  oACG_CommandOption;
  logic [3:0]  oACG_TargetWay;
  logic [15:0] oACG_NumOfData;
  logic        oACG_CASelect;
  logic [39:0] oACG_CAData;
  logic [15:0] oACG_WriteData;
  logic        oACG_WriteLast;
  logic        oACG_WriteValid;
  logic        oACG_ReadReady;
  logic        iACG_Ready;
  logic        iACG_LastStep;
  logic [15:0] iACG_ReadData;
  logic        iACG_ReadValid;
  logic        iACG_ReadLast;

  int passed = 0;
  int total  = 0;

  localparam logic [90:0] IDLE_BUS =
    {8'h00, 3'b000, 4'b0000, 16'h0, 1'b1,
     40'h0, 16'h0, 1'b0, 1'b0, 1'b0};

  logic [90:0] bus;
  assign bus = {oACG_Command, oACG_CommandOption,
                oACG_TargetWay, oACG_NumOfData,
                oACG_CASelect, oACG_CAData,
                oACG_WriteData, oACG_WriteLast,
                oACG_WriteValid, oACG_ReadReady};

  always #5 clk = ~clk;

  nfc_command_read_status #(
    .NumberOfWays(4),
    .WhrCycles(12)
  ) dut (
    .iSystemClock      (clk),
    .iReset            (rst_n),
    .iStart            (iStart),
    .iTargetWay        (iTargetWay),
    .oReady            (oReady),
    .oLastStep         (oLastStep),
    .oStatus           (oStatus),
    .oACG_Command      (oACG_Command),
    .oACG_CommandOption(oACG_CommandOption),
    .oACG_TargetWay    (oACG_TargetWay),
    .oACG_NumOfData    (oACG_NumOfData),
    .oACG_CASelect     (oACG_CASelect),
    .oACG_CAData       (oACG_CAData),
    .oACG_WriteData    (oACG_WriteData),
    .oACG_WriteLast    (oACG_WriteLast),
    .oACG_WriteValid   (oACG_WriteValid),
    .oACG_ReadReady    (oACG_ReadReady),
    .iACG_Ready        (iACG_Ready),
    .iACG_LastStep     (iACG_LastStep),
    .iACG_ReadData     (iACG_ReadData),
    .iACG_ReadValid    (iACG_ReadValid),
    .iACG_ReadLast     (iACG_ReadLast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start through the CA phase and WHR, into RD_DATA.
  task automatic run_to_rd_data(input logic [3:0] way,
                                input bit poke);
    int n;
    iStart     = 1'b1;
    iTargetWay = way;
    iACG_Ready = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    iACG_Ready = 1'b0;
    tick();
    iACG_LastStep = 1'b1;
    tick();
    iACG_LastStep = 1'b0;
    if (poke) begin
      iStart     = 1'b1;
      iTargetWay = 4'b0100;
      tick();
      iStart = 1'b0;
      total++;
      if (oACG_TargetWay !== way || oReady !== 1'b0)
        $display("FAIL poke_way: way=%b ready=%b want way=%b ready=0",
                 oACG_TargetWay, oReady, way);
      else passed++;
    end
    n = 0;
    while (oACG_Command !== 8'h05 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40)
      $display("FAIL rd_issue_timeout: cmd=%h want 05", oACG_Command);
    else passed++;
    iACG_Ready = 1'b1;
    tick();
    iACG_Ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (bus !== IDLE_BUS)
      $display("FAIL reset_bus: got %h want %h", bus, IDLE_BUS);
    else passed++;
    total++;
    if ({oReady, oLastStep, oStatus} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL reset_ctl: rdy=%b last=%b st=%h want 1 0 00",
               oReady, oLastStep, oStatus);
    else passed++;
  endtask

  task automatic test_nominal();
    int n;
    iStart     = 1'b1;
    iTargetWay = 4'b0010;
    iACG_Ready = 1'b1;
    tick();
    iStart = 1'b0;
    total++;
    if (oACG_Command !== 8'h03 || oACG_CAData !== 40'h70 ||
        oACG_CASelect !== 1'b0 || oACG_TargetWay !== 4'b0010 ||
        oReady !== 1'b0)
      $display("FAIL nom_ca: cmd=%h ca=%h sel=%b way=%b rdy=%b",
               oACG_Command, oACG_CAData, oACG_CASelect,
               oACG_TargetWay, oReady);
    else passed++;
    tick();
    iACG_Ready = 1'b0;
    total++;
    if (oACG_Command !== 8'h00 || oACG_TargetWay !== 4'b0010)
      $display("FAIL nom_ca_wait: cmd=%h way=%b want 00 0010",
               oACG_Command, oACG_TargetWay);
    else passed++;
    tick();
    tick();
    iACG_LastStep = 1'b1;
    tick();
    iACG_LastStep = 1'b0;
    n = 0;
    while (oACG_Command !== 8'h05 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== 12)
      $display("FAIL nom_whr_cycles: got %0d want 12", n);
    else passed++;
    total++;
    if (oACG_CASelect !== 1'b1 || oACG_NumOfData !== 16'd0 ||
        oACG_TargetWay !== 4'b0010)
      $display("FAIL nom_rd_issue: sel=%b nod=%h way=%b",
               oACG_CASelect, oACG_NumOfData, oACG_TargetWay);
    else passed++;
    iACG_Ready = 1'b1;
    tick();
    iACG_Ready = 1'b0;
    total++;
    if (oACG_ReadReady !== 1'b1 || oACG_Command !== 8'h00)
      $display("FAIL nom_rd_data: rr=%b cmd=%h want 1 00",
               oACG_ReadReady, oACG_Command);
    else passed++;
    iACG_ReadData  = 16'h00E0;
    iACG_ReadValid = 1'b1;
    iACG_ReadLast  = 1'b1;
    iACG_LastStep  = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    iACG_LastStep  = 1'b0;
    total++;
    if ({oLastStep, oReady, oStatus} !== {1'b1, 1'b0, 8'hE0})
      $display("FAIL nom_done: last=%b rdy=%b st=%h want 1 0 e0",
               oLastStep, oReady, oStatus);
    else passed++;
    tick();
    total++;
    if ({oLastStep, oReady, oStatus} !== {1'b0, 1'b1, 8'hE0})
      $display("FAIL nom_after: last=%b rdy=%b st=%h want 0 1 e0",
               oLastStep, oReady, oStatus);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    int n;
    iStart     = 1'b1;
    iTargetWay = 4'b1000;
    iACG_Ready = 1'b0;
    tick();
    iStart = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (oACG_Command !== 8'h03 || oACG_TargetWay !== 4'b1000 ||
          oACG_CAData !== 40'h70 || oACG_CASelect !== 1'b0)
        bad++;
      tick();
    end
    total++;
    if (bad !== 0) $display("FAIL bp_ca_stable: bad=%0d want 0", bad);
    else passed++;
    iACG_Ready = 1'b1;
    tick();
    iACG_Ready = 1'b0;
    total++;
    if (oACG_Command !== 8'h00)
      $display("FAIL bp_ca_accept: cmd=%h want 00", oACG_Command);
    else passed++;
    iACG_LastStep = 1'b1;
    tick();
    iACG_LastStep = 1'b0;
    n = 0;
    while (oACG_Command !== 8'h05 && n < 40) begin
      n++;
      tick();
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (oACG_Command !== 8'h05 || oACG_TargetWay !== 4'b1000)
        bad++;
      tick();
    end
    total++;
    if (bad !== 0 || n !== 12)
      $display("FAIL bp_rd_stable: bad=%0d whr=%0d want 0 12", bad, n);
    else passed++;
    iACG_Ready = 1'b1;
    tick();
    iACG_Ready = 1'b0;
    total++;
    if (oACG_ReadReady !== 1'b1 || oACG_Command !== 8'h00)
      $display("FAIL bp_rd_accept: rr=%b cmd=%h want 1 00",
               oACG_ReadReady, oACG_Command);
    else passed++;
    iACG_ReadData  = 16'h1233;
    iACG_ReadValid = 1'b1;
    iACG_ReadLast  = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    tick();
    total++;
    if (oACG_ReadReady !== 1'b0 || oLastStep !== 1'b0)
      $display("FAIL bp_rd_wait: rr=%b last=%b want 0 0",
               oACG_ReadReady, oLastStep);
    else passed++;
    iACG_LastStep = 1'b1;
    tick();
    iACG_LastStep = 1'b0;
    total++;
    if (oLastStep !== 1'b1 || oStatus !== 8'h33)
      $display("FAIL bp_done: last=%b st=%h want 1 33",
               oLastStep, oStatus);
    else passed++;
    tick();
  endtask

  task automatic test_multibeat();
    run_to_rd_data(4'b0001, 1'b0);
    iACG_ReadData  = 16'h0040;
    iACG_ReadValid = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    total++;
    if (oACG_ReadReady !== 1'b1 || oStatus !== 8'h40)
      $display("FAIL mb_first: rr=%b st=%h want 1 40",
               oACG_ReadReady, oStatus);
    else passed++;
    tick();
    total++;
    if (oACG_ReadReady !== 1'b1)
      $display("FAIL mb_gap: rr=%b want 1", oACG_ReadReady);
    else passed++;
    iACG_ReadData  = 16'h00FF;
    iACG_ReadValid = 1'b1;
    iACG_ReadLast  = 1'b1;
    iACG_LastStep  = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    iACG_LastStep  = 1'b0;
    total++;
    if (oLastStep !== 1'b1 || oStatus !== 8'h40 ||
        oACG_ReadReady !== 1'b0)
      $display("FAIL mb_done: last=%b st=%h rr=%b want 1 40 0",
               oLastStep, oStatus, oACG_ReadReady);
    else passed++;
    tick();
  endtask

  task automatic test_zero_way();
    int bad;
    iStart     = 1'b1;
    iTargetWay = 4'b0000;
    tick();
    iStart = 1'b0;
    total++;
    if (oLastStep !== 1'b1 || oStatus !== 8'h00 || bus !== IDLE_BUS)
      $display("FAIL zw_done: last=%b st=%h bus=%h",
               oLastStep, oStatus, bus);
    else passed++;
    tick();
    total++;
    if (oLastStep !== 1'b0 || oReady !== 1'b1)
      $display("FAIL zw_after: last=%b rdy=%b want 0 1",
               oLastStep, oReady);
    else passed++;
    run_to_rd_data(4'b0010, 1'b1);
    iACG_ReadData  = 16'h00A5;
    iACG_ReadValid = 1'b1;
    iACG_ReadLast  = 1'b1;
    iACG_LastStep  = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    iACG_LastStep  = 1'b0;
    total++;
    if (oLastStep !== 1'b1 || oStatus !== 8'hA5)
      $display("FAIL ign_done: last=%b st=%h want 1 a5",
               oLastStep, oStatus);
    else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oReady !== 1'b1 || bus !== IDLE_BUS) bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL ign_not_queued: bad=%0d want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    run_to_rd_data(4'b0100, 1'b0);
    total++;
    if (oACG_ReadReady !== 1'b1)
      $display("FAIL rm_in_rd: rr=%b want 1", oACG_ReadReady);
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (bus !== IDLE_BUS || oReady !== 1'b1 ||
        oLastStep !== 1'b0 || oStatus !== 8'h00)
      $display("FAIL rm_idle: bus=%h rdy=%b last=%b st=%h",
               bus, oReady, oLastStep, oStatus);
    else passed++;
    run_to_rd_data(4'b0001, 1'b0);
    iACG_ReadData  = 16'h005A;
    iACG_ReadValid = 1'b1;
    iACG_ReadLast  = 1'b1;
    iACG_LastStep  = 1'b1;
    tick();
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    iACG_LastStep  = 1'b0;
    total++;
    if (oLastStep !== 1'b1 || oStatus !== 8'h5A)
      $display("FAIL rm_fresh: last=%b st=%h want 1 5a",
               oLastStep, oStatus);
    else passed++;
    tick();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      iACG_LastStep  = i[0];
      iACG_ReadValid = i[1];
      iACG_ReadData  = 16'h00C3;
      tick();
      if (bus !== IDLE_BUS || oReady !== 1'b1 ||
          oStatus !== 8'h5A)
        bad++;
    end
    iACG_LastStep  = 1'b0;
    iACG_ReadValid = 1'b0;
    total++;
    if (bad !== 0)
      $display("FAIL idle_pattern: bad=%0d want 0", bad);
    else passed++;
  endtask

  initial begin
    rst_n          = 1'b0;
    iStart         = 1'b0;
    iTargetWay     = 4'b0000;
    iACG_Ready     = 1'b0;
    iACG_LastStep  = 1'b0;
    iACG_ReadData  = 16'h0;
    iACG_ReadValid = 1'b0;
    iACG_ReadLast  = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_multibeat();
    test_zero_way();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
